// File: rtl/poker_pkg.sv
// Shared card encoding and deck helpers for the poker datapath.
// Card = {suit[1:0], rank[3:0]}, rank 2..14, 6'd0 means empty.
package poker_pkg;

  localparam int SUIT_W = 2;
  localparam int RANK_W = 4;
  localparam int CARD_W = SUIT_W + RANK_W;

  typedef logic [CARD_W-1:0] card_t;

  localparam logic [RANK_W-1:0] RANK_MIN = 4'd2;
  localparam logic [RANK_W-1:0] RANK_MAX = 4'd14;
  localparam int DECK_SIZE = 52;
  localparam card_t CARD_EMPTY = 6'd0;

  function automatic logic card_valid(card_t c);
    return (c[3:0] >= RANK_MIN) && (c[3:0] <= RANK_MAX);
  endfunction

  // suit*13 + rank - 2; only meaningful for valid cards
  function automatic logic [5:0] card_index(card_t c);
    logic [5:0] s;
    logic [5:0] r;
    s = {4'b0, c[5:4]};
    r = {2'b0, c[3:0]};
    return (s << 3) + (s << 2) + s + r - 6'd2;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, with advance and load.
// A zero load value falls back to SEED so the register never locks up.
module card_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  assign fb = lfsr_q[15] ^ lfsr_q[13]
            ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (load_val_i == 16'h0)
             ? SEED : load_val_i;
    end else if (adv_i) begin
      lfsr_d = {lfsr_q[14:0], fb};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// Deals 5 unique cards per hand from a 52-card deck using an LFSR.
// Optional CARD_DEALER_SEED_EN adds seed_valid/seed LFSR reseeding.
module card_dealer
  import poker_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          HAND_SIZE = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        shuffle,
  input  logic        deal_req,
`ifdef CARD_DEALER_SEED_EN
  input  logic        seed_valid,
  input  logic [15:0] seed,
`endif
  output logic        ready,
  output logic        init,
  output card_t       card0,
  output card_t       card1,
  output card_t       card2,
  output card_t       card3,
  output card_t       card4,
  output logic [5:0]  cards_left,
  output logic        deal_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic [5:0] LEFT_FULL = 6'(DECK_SIZE);
  localparam logic [5:0] HAND_N    = 6'(HAND_SIZE);
  localparam logic [2:0] K_LAST    = 3'(HAND_SIZE - 1);

  logic [1:0]           state_q, state_d;
  logic [DECK_SIZE-1:0] mask_q, mask_d;
  logic [2:0]           k_q, k_d;
  card_t                hand_q [HAND_SIZE];
  card_t                hand_d [HAND_SIZE];
  card_t                card_q [HAND_SIZE];
  card_t                card_d [HAND_SIZE];
  logic [5:0]           left_q, left_d;
  logic                 err_q, err_d;

  logic [15:0] lfsr;
  logic        lfsr_adv;
  logic        lfsr_load;
  logic [15:0] lfsr_val;
  logic        seed_req;

  card_t       cand;
  logic [5:0]  cidx;
  logic [63:0] mask_x;
  logic        cand_ok;

`ifdef CARD_DEALER_SEED_EN
  assign seed_req = seed_valid;
  assign lfsr_val = seed;
`else
  assign seed_req = 1'b0;
  assign lfsr_val = 16'h0;
`endif

  card_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .adv_i      (lfsr_adv),
    .load_i     (lfsr_load),
    .load_val_i (lfsr_val),
    .lfsr_o     (lfsr)
  );

  assign cand    = lfsr[5:0];
  assign cidx    = card_index(cand);
  assign mask_x  = {{(64-DECK_SIZE){1'b0}}, mask_q};
  assign cand_ok = card_valid(cand) && !mask_x[cidx];

  assign lfsr_adv = (state_q == S_DRAW);

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    k_d       = k_q;
    hand_d    = hand_q;
    card_d    = card_q;
    left_d    = left_q;
    err_d     = 1'b0;
    lfsr_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (seed_req) begin
          lfsr_load = 1'b1;
        end else if (shuffle) begin
          mask_d = '0;
          left_d = LEFT_FULL;
        end else if (deal_req) begin
          if (left_q >= HAND_N) begin
            k_d     = 3'd0;
            state_d = S_DRAW;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DRAW: begin
        if (cand_ok) begin
          hand_d[k_q] = cand;
          mask_d = mask_q
                 | (DECK_SIZE'(1) << cidx);
          k_d = k_q + 3'd1;
          // publish on entry to EMIT so init and cards coincide
          if (k_q == K_LAST) begin
            for (int i = 0; i < HAND_SIZE - 1; i++)
              card_d[i] = hand_q[i];
            card_d[HAND_SIZE-1] = cand;
            left_d  = left_q - HAND_N;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      k_q     <= 3'd0;
      hand_q  <= '{default: CARD_EMPTY};
      card_q  <= '{default: CARD_EMPTY};
      left_q  <= LEFT_FULL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      k_q     <= k_d;
      hand_q  <= hand_d;
      card_q  <= card_d;
      left_q  <= left_d;
      err_q   <= err_d;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign init       = (state_q == S_EMIT);
  assign card0      = card_q[0];
  assign card1      = card_q[1];
  assign card2      = card_q[2];
  assign card3      = card_q[3];
  assign card4      = card_q[4];
  assign cards_left = left_q;
  assign deal_err   = err_q;

endmodule
